// File: rtl/seg_scan_pkg.sv
// ============================================================================
// seg_scan_pkg : scan-FSM state codes and 7-segment patterns (bit 0 = seg a)
// Revision     : 1.0
// ============================================================================
`default_nettype none

package seg_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_D0 = 2'd0;
  localparam state_t S_G0 = 2'd1;
  localparam state_t S_D1 = 2'd2;
  localparam state_t S_G1 = 2'd3;

  // Literal MSB lands on index 0, so each pattern reads a..g left to right.
  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b0000001;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;

endpackage

`default_nettype wire

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// ============================================================================
// bcd_to_seg : combinational BCD to 7-segment decoder, codes above 9 -> dash
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [0:6] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// seg_scan_driver : two-digit multiplexed 7-segment scanner with per-frame
//                   digit snapshot. Option macro: LEADING_ZERO_BLANK_EN.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int GAP   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  output logic [0:6] seg,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int     c_MAXV   = (DWELL > GAP) ? DWELL : GAP;
  localparam int     CNT_W    = (c_MAXV > 1) ? $clog2(c_MAXV) : 1;
  localparam bit     c_HAS_GAP = (GAP > 0);
  localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST   = c_HAS_GAP ? CNT_W'(GAP - 1) : '0;
  // Without gaps the reset state is the tens slot, held dark until it ends.
  localparam state_t c_RESET_STATE = c_HAS_GAP ? S_G1 : S_D1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       units_q, units_d, tens_q, tens_d;
  seg_t             seg_d;
  logic [1:0]       an_d;
  logic             fs_d;
  logic             state_chg, enter_d0;
  logic [3:0]       dec_in;
  seg_t             dec_out;

  bcd_to_seg u_dec (
    .bcd_i (dec_in),
    .seg_o (dec_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_D0:    if (cnt_q == c_DWELL_LAST) state_d = c_HAS_GAP ? S_G0 : S_D1;
      S_G0:    if (cnt_q == c_GAP_LAST)   state_d = S_D1;
      S_D1:    if (cnt_q == c_DWELL_LAST) state_d = c_HAS_GAP ? S_G1 : S_D0;
      default: if (cnt_q == c_GAP_LAST)   state_d = S_D0;
    endcase

    state_chg = (state_d != state_q);
    enter_d0  = state_chg && (state_d == S_D0);
    cnt_d     = state_chg ? '0 : cnt_q + 1'b1;
    units_d   = enter_d0 ? units : units_q;
    tens_d    = enter_d0 ? tens  : tens_q;
    dec_in    = (state_d == S_D0) ? units_d : tens_d;
    fs_d      = enter_d0;

    // Outputs are constant within a state, so they only reload on transitions.
    seg_d = seg;
    an_d  = an;
    if (state_chg) begin
      case (state_d)
        S_D0: begin
          an_d  = 2'b01;
          seg_d = dec_out;
        end
        S_D1: begin
          an_d  = 2'b10;
          seg_d = dec_out;
`ifdef LEADING_ZERO_BLANK_EN
          if (tens_d == 4'd0) begin
            an_d  = 2'b00;
            seg_d = SEG_BLANK;
          end
`endif
        end
        default: begin
          an_d  = 2'b00;
          seg_d = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= c_RESET_STATE;
      cnt_q       <= '0;
      units_q     <= 4'd0;
      tens_q      <= 4'd0;
      seg         <= SEG_BLANK;
      an          <= 2'b00;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      seg         <= seg_d;
      an          <= an_d;
      frame_start <= fs_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// tb_seg_scan_driver : frame-position reference model for two scan drivers
//                      (DWELL=4 with GAP=2 and GAP=0) driven by shared inputs.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] units, tens;
  logic [0:6] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       fs_a, fs_b;

  seg_scan_driver #(.DWELL(D), .GAP(G)) dut_a (
    .clk (clk), .reset (reset), .units (units), .tens (tens),
    .seg (seg_a), .an (an_a), .frame_start (fs_a)
  );

  seg_scan_driver #(.DWELL(D), .GAP(0)) dut_b (
    .clk (clk), .reset (reset), .units (units), .tens (tens),
    .seg (seg_b), .an (an_b), .frame_start (fs_b)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc;
  logic [3:0] snap_u [2];
  logic [3:0] snap_t [2];

  function automatic logic [6:0] pat(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return (v > 4'd9) ? 7'b0000001 : tbl[v];
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? G : 0;
  endfunction

  // Cycle number (1 = first cycle after reset release) of the first units slot.
  function automatic int first_d0(input int g);
    return (g > 0) ? g + 1 : D + 1;
  endfunction

  function automatic int phase(input int g, input int c);
    if (c < first_d0(g)) return -1;
    return (c - first_d0(g)) % (2 * (D + g));
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic check_now();
    for (int i = 0; i < 2; i++) begin
      int         g, p;
      logic [6:0] e_seg;
      logic [1:0] e_an;
      logic       e_fs;
      g     = gap_of(i);
      p     = phase(g, cyc);
      e_seg = 7'b0;
      e_an  = 2'b00;
      e_fs  = 1'b0;
      if (p >= 0 && p < D) begin
        e_an  = 2'b01;
        e_seg = pat(snap_u[i]);
        e_fs  = (p == 0);
      end else if (p >= D + g && p < 2 * D + g) begin
        e_an  = 2'b10;
        e_seg = pat(snap_t[i]);
`ifdef LEADING_ZERO_BLANK_EN
        if (snap_t[i] == 4'd0) begin
          e_an  = 2'b00;
          e_seg = 7'b0;
        end
`endif
      end
      chk("seg", i, 32'((i == 0) ? seg_a : seg_b), 32'(e_seg));
      chk("an",  i, 32'((i == 0) ? an_a  : an_b),  32'(e_an));
      chk("frame_start", i, 32'((i == 0) ? fs_a : fs_b), 32'(e_fs));
    end
  endtask

  // One clock edge with the inputs currently applied, then compare.
  task automatic step();
    cyc++;
    for (int i = 0; i < 2; i++)
      if (phase(gap_of(i), cyc) == 0) begin
        snap_u[i] = units;
        snap_t[i] = tens;
      end
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc   = 1;
    for (int i = 0; i < 2; i++) begin
      snap_u[i] = 4'd0;
      snap_t[i] = 4'd0;
    end
    check_now();
  endtask

  task automatic rand_steps(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) units = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tens  = ($urandom_range(0, 2) == 0) ? 4'd0
                                             : 4'($urandom_range(0, 15));
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    units = 4'd3;
    tens  = 4'd7;
    cyc   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an",  0, 32'(an_a),  32'd0);
    chk("reset_seg", 1, 32'(seg_b), 32'd0);
    release_reset();

    // Steady 37: two gap cycles, units 3 for four, gap, tens 7 for four.
    repeat (30) step();

    // Change units during the units slot; the snapshot must hold until next frame.
    while (phase(G, cyc) != 1) step();
    units = 4'd8;
    repeat (14) step();

    // Out-of-range code and a zero tens digit.
    units = 4'hC;
    tens  = 4'd0;
    repeat (26) step();
    units = 4'd5;
    repeat (26) step();

    rand_steps(300);

    // Asynchronous reset in the second cycle of the tens slot of dut_a.
    for (int k = 0; k < 40 && phase(G, cyc) != D + G + 1; k++) step();
    chk("reach_d1_cycle2", 0, 32'(phase(G, cyc)), 32'(D + G + 1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_seg", 0, 32'(seg_a), 32'd0);
    chk("async_an",  0, 32'(an_a),  32'd0);
    chk("async_fs",  0, 32'(fs_a),  32'd0);
    chk("async_an",  1, 32'(an_b),  32'd0);
    release_reset();
    units = 4'd9;
    tens  = 4'd1;
    repeat (12) step();
    rand_steps(120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
